ts_sample_packer: RTL and testbench
===================================

Name: ts_sample_packer

Overview:
- Sits directly downstream of the temperature-sensor controller, between the I2C receive byte stream and the PC wire-out (`PC_tx`, endpoint 0x20).
- Pairs the ADT7420 MSB/LSB temperature bytes into one 13-bit signed sample.
- Averages 2^AVG_LOG2 samples and publishes a 32-bit status/temperature word for the host, with sequence and error counters.
- Converts the raw per-byte I2C result into a stable, host-readable measurement.

Parameters:
- AVG_LOG2, 2: log2 of samples per average. Legal range 0..4; 0 = pass-through.
- TIMEOUT_CYCLES, 2000000: maximum clk cycles allowed between the MSB and LSB bytes.

Ports:
- clk  in  1  system clock (200 MHz differential-buffered domain)
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear, driven from a PC_rx bit; one-cycle or level
- byte_valid  in  1  one-cycle strobe; rx_byte holds a fresh byte
- byte_first  in  1  qualifies byte_valid: 1 = MSB byte, 0 = LSB byte
- rx_byte  in  8  received byte from the I2C stage
- tx_word  out  32  {seq[7:0], err_cnt[3:0], 4'b0, avg[15:0]}; drives PC_tx
- word_valid  out  1  one-cycle pulse when tx_word updates
- busy  out  1  high while in WAIT_LSB

Behaviour:
- Reset (rst_n low, async): state = IDLE; tx_word = 0; word_valid = 0; busy = 0; accumulator, sample count, seq and err_cnt = 0.
- clear = 1 at a clk edge: same effect as reset, but synchronous. clear takes priority over a simultaneous byte_valid, and that byte is dropped.
- FSM states: IDLE, WAIT_LSB.
  - IDLE + byte_valid + byte_first: latch MSB, go to WAIT_LSB, load timeout counter = 0.
  - IDLE + byte_valid + !byte_first: drop the byte, err_cnt +1, stay in IDLE.
  - WAIT_LSB + byte_valid + !byte_first: form raw = {msb, lsb}; sample = raw[15:3] (signed 13-bit); accumulate; go to IDLE.
  - WAIT_LSB + byte_valid + byte_first: err_cnt +1; re-latch the new MSB; stay in WAIT_LSB; restart the timeout.
  - WAIT_LSB with timeout counter == TIMEOUT_CYCLES-1 and no byte: err_cnt +1, discard the MSB, go to IDLE.
- Accumulator: signed, 13+AVG_LOG2 bits, with the sample sign-extended. The sample counter counts 0..2^AVG_LOG2-1.
- On the sample that completes a block:
  - avg = acc >>> AVG_LOG2, an arithmetic shift (floor toward −inf), sign-extended to 16 bits.
  - Accumulator and counter reset to 0 in the same cycle; the next sample starts a new block with no sample lost.
- Output latency: tx_word and word_valid update on the clk edge after the completing LSB's byte_valid (1-cycle registered). tx_word holds its value between updates.
- seq increments by 1 per published word and wraps 0xFF -> 0x00. err_cnt saturates at 0xF.
- Raw LSB bits [2:0] (ADT7420 flag bits) are ignored.
- busy = (state == WAIT_LSB), registered.

Decomposition:
- Shared package `ts_pkg` holds:
  - state encoding: IDLE = 1'b0, WAIT_LSB = 1'b1
  - the field offsets SEQ_LSB = 24, ERR_LSB = 20, AVG_LSB = 0
  - ADT7420 constants: TEMP_SHIFT = 3, TEMP_BITS = 13
- One sub-module, `ts_avg_accum`, is natural: accumulator + sample counter + shift. Inputs are the sample, a strobe and a clear; outputs are avg and done.
- Pairing FSM, timeout and counters stay in the top module.

Test Plan:
- AVG_LOG2=0; MSB 0x0C, LSB 0x80 -> one word_valid pulse; tx_word = 0x00000190 (25.0 °C); next pair 0x0C/0x88 -> tx_word = 0x01000191.
- AVG_LOG2=2; samples 400, 400, 408, 408 -> a single word_valid after the 4th LSB; avg = 0x0194. No pulse after samples 1–3.
- AVG_LOG2=2; negative samples −25, −26, −25, −26 (0xFF38, 0xFF30, …) -> avg = 0xFFE6 (−26, floor).
- LSB with no MSB -> err_cnt = 1, no word. Then MSB, MSB, LSB -> err_cnt = 2, and the sample is built from the second MSB.
- TIMEOUT_CYCLES=10; MSB, then idle 10 cycles -> busy drops at cycle 10, err_cnt +1; a following LSB counts as a further error. 17 errors in total -> err_cnt stays at 0xF.
- Assert rst_n low mid-WAIT_LSB, and separately assert clear coincident with an LSB byte_valid -> all outputs = 0, no word_valid, and the next clean pair yields seq = 0x00.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared encodings and constants for the temperature-sample packer.
package ts_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LSB = 1'b1
    } state_t;

    // Bit offsets of the fields inside the host status word.
    localparam int SEQ_LSB = 24;
    localparam int ERR_LSB = 20;
    localparam int AVG_LSB = 0;

    // The ADT7420 delivers a 13-bit temperature left-justified in 16 bits.
    // The low three bits are flags and carry no temperature information.
    localparam int TEMP_SHIFT = 3;
    localparam int TEMP_BITS  = 13;

    // Build the signed 13-bit sample from the MSB/LSB byte pair.
    function automatic logic [TEMP_BITS-1:0] raw_to_sample(input logic [7:0] msb,
                                                           input logic [7:0] lsb);
        logic [15:0] raw;
        raw = {msb, lsb};
        return raw[TEMP_SHIFT +: TEMP_BITS];
    endfunction

endpackage

// File: rtl/ts_avg_accum.sv
// Block averager: sums 2^AVG_LOG2 signed samples and emits their floored mean.
module ts_avg_accum
    import ts_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample_vld,
    input  logic [TEMP_BITS-1:0] sample,
    output logic [15:0]          avg,
    output logic                 done
);

    localparam int AW = TEMP_BITS + AVG_LOG2;
    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sample_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic [CW-1:0]        cnt;

    // The completing sample is folded into the sum combinationally so the
    // average is ready in the same cycle the last sample arrives.
    always_comb begin
        sample_ext = AW'($signed(sample));
        sum        = acc + sample_ext;
        shifted    = sum >>> AVG_LOG2;
        avg        = 16'($signed(shifted[TEMP_BITS-1:0]));
        done       = sample_vld && (cnt == CW'((1 << AVG_LOG2) - 1));
    end

    // Accumulate; restart the block on the completing sample so the next
    // sample lands in a fresh block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample_vld) begin
            if (done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ts_sample_packer.sv
// Pairs ADT7420 MSB/LSB bytes into samples, averages them and publishes a
// 32-bit {seq, err_cnt, 0, avg} word for the host.
module ts_sample_packer
    import ts_pkg::*;
#(
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic        byte_first,
    input  logic [7:0]  rx_byte,
    output logic [31:0] tx_word,
    output logic        word_valid,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t               state, state_nxt;
    logic [7:0]           msb, msb_nxt;
    logic [TW-1:0]        tcnt, tcnt_nxt;
    logic [7:0]           seq;
    logic [3:0]           err_cnt;
    logic                 err_inc;
    logic                 sample_vld;
    logic [TEMP_BITS-1:0] sample;
    logic [15:0]          avg;
    logic                 done;
    logic [31:0]          word_nxt;

    // Pairing FSM: next state, MSB latch, timeout counter and error strobe.
    always_comb begin
        state_nxt  = state;
        msb_nxt    = msb;
        tcnt_nxt   = tcnt;
        err_inc    = 1'b0;
        sample_vld = 1'b0;
        case (state)
            IDLE: begin
                if (byte_valid) begin
                    if (byte_first) begin
                        msb_nxt   = rx_byte;
                        tcnt_nxt  = '0;
                        state_nxt = WAIT_LSB;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            WAIT_LSB: begin
                if (byte_valid) begin
                    if (byte_first) begin
                        // A second MSB replaces the first; the stale one is an error.
                        err_inc  = 1'b1;
                        msb_nxt  = rx_byte;
                        tcnt_nxt = '0;
                    end else begin
                        sample_vld = 1'b1;
                        state_nxt  = IDLE;
                    end
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sample = raw_to_sample(msb, rx_byte);

    ts_avg_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_vld (sample_vld),
        .sample     (sample),
        .avg        (avg),
        .done       (done)
    );

    // Assemble the host word from the current seq and error counters.
    always_comb begin
        word_nxt                   = '0;
        word_nxt[SEQ_LSB +: 8]     = seq;
        word_nxt[ERR_LSB +: 4]     = err_cnt;
        word_nxt[AVG_LSB +: 16]    = avg;
    end

    // State, counters and the registered host interface; clear drops any
    // byte arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            msb        <= '0;
            tcnt       <= '0;
            seq        <= '0;
            err_cnt    <= '0;
            tx_word    <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            msb        <= '0;
            tcnt       <= '0;
            seq        <= '0;
            err_cnt    <= '0;
            tx_word    <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            msb        <= msb_nxt;
            tcnt       <= tcnt_nxt;
            busy       <= (state_nxt == WAIT_LSB);
            word_valid <= done;
            if (done) begin
                tx_word <= word_nxt;
                seq     <= seq + 8'd1;
            end
            if (err_inc && (err_cnt != 4'hF))
                err_cnt <= err_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_ts_sample_packer.sv
// Directed bench: a pass-through packer and a 4-sample averager share one
// byte stream; expected words are hand-computed constants.
module tb_ts_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n, clear, byte_valid, byte_first;
    logic [7:0]  rx_byte;
    logic [31:0] tx_word0, tx_word2;
    logic        wv0, wv2, busy0, busy2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ts_sample_packer #(.AVG_LOG2(0), .TIMEOUT_CYCLES(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .byte_valid(byte_valid),
        .byte_first(byte_first), .rx_byte(rx_byte),
        .tx_word(tx_word0), .word_valid(wv0), .busy(busy0));

    ts_sample_packer #(.AVG_LOG2(2), .TIMEOUT_CYCLES(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .byte_valid(byte_valid),
        .byte_first(byte_first), .rx_byte(rx_byte),
        .tx_word(tx_word2), .word_valid(wv2), .busy(busy2));

    typedef struct {
        logic [7:0]  msb;
        logic [7:0]  lsb;
        logic [31:0] w0;   // pass-through word after this pair
        logic        wv2;  // averager publishes on this pair
        logic [31:0] w2;   // averager word (held value when no publish)
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic send(input logic first, input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1; byte_first = first; rx_byte = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Returns on the negedge right after the LSB edge, while word_valid is up.
    task automatic pair(input logic [7:0] m, input logic [7:0] l);
        send(1'b1, m);
        send(1'b0, l);
    endtask

    initial begin
        vecs[0] = '{8'h0C, 8'h80, 32'h00000190, 1'b0, 32'h00000000};
        vecs[1] = '{8'h0C, 8'h88, 32'h01000191, 1'b0, 32'h00000000};
        vecs[2] = '{8'h0C, 8'hC0, 32'h02000198, 1'b0, 32'h00000000};
        vecs[3] = '{8'h0C, 8'hC0, 32'h03000198, 1'b1, 32'h00000194};
        vecs[4] = '{8'hFF, 8'h38, 32'h0400FFE7, 1'b0, 32'h00000194};
        vecs[5] = '{8'hFF, 8'h30, 32'h0500FFE6, 1'b0, 32'h00000194};
        vecs[6] = '{8'hFF, 8'h38, 32'h0600FFE7, 1'b0, 32'h00000194};
        vecs[7] = '{8'hFF, 8'h30, 32'h0700FFE6, 1'b1, 32'h0100FFE6};

        rst_n = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_first = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset tx_word0", tx_word0, 32'h0);
        chk("reset tx_word2", tx_word2, 32'h0);
        chk("reset wv",       32'({wv0, wv2}), 32'h0);
        chk("reset busy",     32'({busy0, busy2}), 32'h0);
        rst_n = 1'b1;

        // Table: pass-through words and a positive then a negative average block.
        for (int i = 0; i < 8; i++) begin
            send(1'b1, vecs[i].msb);
            chk($sformatf("v%0d busy after msb", i), 32'(busy0), 32'h1);
            chk($sformatf("v%0d wv0 after msb", i), 32'(wv0), 32'h0);
            send(1'b0, vecs[i].lsb);
            chk($sformatf("v%0d wv0", i), 32'(wv0), 32'h1);
            chk($sformatf("v%0d tx_word0", i), tx_word0, vecs[i].w0);
            chk($sformatf("v%0d wv2", i), 32'(wv2), 32'(vecs[i].wv2));
            chk($sformatf("v%0d tx_word2", i), tx_word2, vecs[i].w2);
            chk($sformatf("v%0d busy after lsb", i), 32'(busy0), 32'h0);
        end

        // Orphan LSB: one error, no word.
        send(1'b0, 8'h80);
        chk("orphan lsb wv0", 32'(wv0), 32'h0);
        chk("orphan lsb tx_word0 held", tx_word0, 32'h0700FFE6);

        // MSB, MSB, LSB: second MSB wins, error count now 2.
        send(1'b1, 8'h0C);
        send(1'b1, 8'h0D);
        send(1'b0, 8'h00);
        chk("double msb wv0", 32'(wv0), 32'h1);
        chk("double msb tx_word0", tx_word0, 32'h082001A0);
        chk("double msb wv2", 32'(wv2), 32'h0);

        // Timeout: busy holds for 9 edges after the MSB and drops on the 10th.
        send(1'b1, 8'h0C);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 9)  chk("timeout busy before", 32'(busy0), 32'h1);
            if (k == 10) chk("timeout busy after",  32'(busy0), 32'h0);
        end
        send(1'b0, 8'h80);   // late LSB: another error
        chk("late lsb wv0", 32'(wv0), 32'h0);
        pair(8'h0C, 8'h80);
        chk("after timeout tx_word0", tx_word0, 32'h09400190);

        // 13 more errors: 17 in total, saturates at 0xF.
        for (int k = 0; k < 13; k++) send(1'b0, 8'h80);
        pair(8'h0C, 8'h80);
        chk("err sat tx_word0", tx_word0, 32'h0AF00190);
        chk("err sat wv2", 32'(wv2), 32'h0);
        pair(8'h0C, 8'h80);
        chk("err sat tx_word2", tx_word2, 32'h02F00194);
        chk("err sat wv2 pulse", 32'(wv2), 32'h1);

        // Async reset in the middle of WAIT_LSB.
        send(1'b1, 8'h0C);
        chk("pre-reset busy", 32'(busy0), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset tx_word0", tx_word0, 32'h0);
        chk("mid reset tx_word2", tx_word2, 32'h0);
        chk("mid reset busy/wv", 32'({busy0, busy2, wv0, wv2}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pair(8'h0C, 8'h80);
        chk("post reset tx_word0", tx_word0, 32'h00000190);
        chk("post reset tx_word2", tx_word2, 32'h0);
        for (int k = 0; k < 3; k++) pair(8'h0C, 8'h80);
        chk("post reset tx_word2 seq0", tx_word2, 32'h00000190);
        chk("post reset tx_word0 seq3", tx_word0, 32'h03000190);

        // clear coincident with an LSB: byte dropped, everything zeroed.
        send(1'b1, 8'h0C);
        @(negedge clk);
        byte_valid = 1'b1; byte_first = 1'b0; rx_byte = 8'h80; clear = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; clear = 1'b0;
        chk("clear tx_word0", tx_word0, 32'h0);
        chk("clear tx_word2", tx_word2, 32'h0);
        chk("clear busy/wv", 32'({busy0, busy2, wv0, wv2}), 32'h0);
        pair(8'h0C, 8'h80);
        chk("post clear tx_word0", tx_word0, 32'h00000190);
        chk("post clear wv2", 32'(wv2), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
